// File: rtl/mioc_tester_pkg.sv
// mioc_tester_pkg: shared state encoding and constants for the MIOC pattern tester
package mioc_tester_pkg;

    localparam int SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SETTLE,
        SYNC,
        SAMPLE,
        DONE
    } state_e;

endpackage

// File: rtl/mioc_pattern_mem.sv
// mioc_pattern_mem: pattern register file, one write port and one asynchronous read port
module mioc_pattern_mem #(
    parameter int DEPTH = 16,
    parameter int W     = 6,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem_q [DEPTH];

    // contents are deliberately not reset so patterns survive a tester reset
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/mioc_pattern_tester.sv
// mioc_pattern_tester: applies stored stimulus to a gate, samples and checks its response
module mioc_pattern_tester
    import mioc_tester_pkg::*;
#(
    parameter int N_IN     = 4,
    parameter int N_OUT    = 1,
    parameter int DEPTH    = 16,
    parameter int SETTLE_W = 8,
    parameter int ERR_W    = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [N_IN-1:0]          wr_stim,
    input  logic [N_OUT-1:0]         wr_exp,
    input  logic [N_OUT-1:0]         wr_mask,
    input  logic [$clog2(DEPTH)-1:0] last_idx,
    input  logic [SETTLE_W-1:0]      settle_cycles,
    input  logic                     loop_mode,
    input  logic                     start,
    input  logic                     stop,
    output logic [N_IN-1:0]          dut_in,
    input  logic [N_OUT-1:0]         dut_out,
    output logic                     busy,
    output logic                     done,
    output logic                     aborted,
    output logic [ERR_W-1:0]         err_cnt,
    output logic                     first_err_valid,
    output logic [$clog2(DEPTH)-1:0] first_err_idx,
    output logic [7:0]               pass_cnt,
    output logic                     smp_valid,
    output logic [$clog2(DEPTH)-1:0] smp_idx,
    output logic [N_OUT-1:0]         smp_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int W  = N_IN + 2 * N_OUT;

    state_e               state_q, state_d;
    logic [AW-1:0]        idx_q, idx_d;
    logic [AW-1:0]        first_err_idx_q, first_err_idx_d;
    logic [SETTLE_W-1:0]  cnt_q, cnt_d;
    logic [N_IN-1:0]      dut_in_q, dut_in_d;
    logic [N_OUT-1:0]     sync1_q, sync2_q;
    logic [ERR_W-1:0]     err_cnt_q, err_cnt_d;
    logic                 first_err_valid_q, first_err_valid_d;
    logic                 done_q, done_d;
    logic                 aborted_q, aborted_d;
    logic [7:0]           pass_cnt_q, pass_cnt_d;
    logic [W-1:0]         rd_word;
    logic [N_IN-1:0]      rd_stim;
    logic [N_OUT-1:0]     rd_exp, rd_mask;
    logic                 active, mismatch;

    assign active   = state_q inside {APPLY, SETTLE, SYNC, SAMPLE};
    assign {rd_stim, rd_exp, rd_mask} = rd_word;
    assign mismatch = |((sync2_q ^ rd_exp) & rd_mask);

    mioc_pattern_mem #(.DEPTH(DEPTH), .W(W)) u_mem (
        .clk   (clk),
        .we    (wr_en & ~active),
        .waddr (wr_addr),
        .wdata ({wr_stim, wr_exp, wr_mask}),
        .raddr (idx_q),
        .rdata (rd_word)
    );

    // sequencer: stop overrides everything while busy, otherwise step through the per-pattern phases
    always_comb begin
        state_d           = state_q;
        idx_d             = idx_q;
        cnt_d             = cnt_q;
        dut_in_d          = dut_in_q;
        err_cnt_d         = err_cnt_q;
        first_err_valid_d = first_err_valid_q;
        first_err_idx_d   = first_err_idx_q;
        pass_cnt_d        = pass_cnt_q;
        done_d            = done_q;
        aborted_d         = aborted_q;
        if (active && stop) begin
            state_d   = DONE;
            done_d    = 1'b1;
            aborted_d = 1'b1;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start && !stop) begin
                        state_d           = APPLY;
                        idx_d             = '0;
                        err_cnt_d         = '0;
                        first_err_valid_d = 1'b0;
                        first_err_idx_d   = '0;
                        pass_cnt_d        = '0;
                        done_d            = 1'b0;
                        aborted_d         = 1'b0;
                    end
                end
                APPLY: begin
                    dut_in_d = rd_stim;
                    cnt_d    = settle_cycles;
                    state_d  = SETTLE;
                end
                SETTLE: begin
                    state_d = cnt_q <= SETTLE_W'(1) ? SYNC : SETTLE;
                    cnt_d   = cnt_q <= SETTLE_W'(1) ? SETTLE_W'(SYNC_STAGES - 1) : cnt_q - SETTLE_W'(1);
                end
                SYNC: begin
                    state_d = cnt_q == '0 ? SAMPLE : SYNC;
                    cnt_d   = cnt_q - SETTLE_W'(1);
                end
                SAMPLE: begin
                    if (mismatch) begin
                        err_cnt_d = &err_cnt_q ? err_cnt_q : err_cnt_q + ERR_W'(1);
                        if (!first_err_valid_q) begin
                            first_err_valid_d = 1'b1;
                            first_err_idx_d   = idx_q;
                        end
                    end
                    if (idx_q != last_idx) begin
                        idx_d   = idx_q + AW'(1);
                        state_d = APPLY;
                    end else if (loop_mode) begin
                        pass_cnt_d = pass_cnt_q + 8'd1;
                        idx_d      = '0;
                        state_d    = APPLY;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // state registers plus the two-stage synchroniser on the gate outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q           <= IDLE;
            idx_q             <= '0;
            cnt_q             <= '0;
            dut_in_q          <= '0;
            sync1_q           <= '0;
            sync2_q           <= '0;
            err_cnt_q         <= '0;
            first_err_valid_q <= 1'b0;
            first_err_idx_q   <= '0;
            pass_cnt_q        <= '0;
            done_q            <= 1'b0;
            aborted_q         <= 1'b0;
        end else begin
            state_q           <= state_d;
            idx_q             <= idx_d;
            cnt_q             <= cnt_d;
            dut_in_q          <= dut_in_d;
            sync1_q           <= dut_out;
            sync2_q           <= sync1_q;
            err_cnt_q         <= err_cnt_d;
            first_err_valid_q <= first_err_valid_d;
            first_err_idx_q   <= first_err_idx_d;
            pass_cnt_q        <= pass_cnt_d;
            done_q            <= done_d;
            aborted_q         <= aborted_d;
        end
    end

    assign dut_in          = dut_in_q;
    assign busy            = active;
    assign done            = done_q;
    assign aborted         = aborted_q;
    assign err_cnt         = err_cnt_q;
    assign first_err_valid = first_err_valid_q;
    assign first_err_idx   = first_err_idx_q;
    assign pass_cnt        = pass_cnt_q;
    assign smp_valid       = (state_q == SAMPLE) & ~stop;
    assign smp_idx         = idx_q;
    assign smp_data        = sync2_q;

endmodule

// File: tb/tb_mioc_pattern_tester.sv
// tb_mioc_pattern_tester: directed checks of the pattern tester driving an inverter model
module tb_mioc_pattern_tester;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [0:0]    wr_stim = '0, wr_exp = '0, wr_mask = '0;
    logic [AW-1:0] last_idx = '0;
    logic [7:0]    settle_cycles = '0;
    logic          loop_mode = 1'b0, start = 1'b0, stop = 1'b0;
    logic [0:0]    dut_in, dut_out;
    logic          busy, done, aborted, first_err_valid, smp_valid;
    logic [3:0]    err_cnt;
    logic [AW-1:0] first_err_idx, smp_idx;
    logic [7:0]    pass_cnt;
    logic [0:0]    smp_data;

    logic d1 = 1'b0, d2 = 1'b0, d3 = 1'b0, gate_fast = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    mioc_pattern_tester #(
        .N_IN(1), .N_OUT(1), .DEPTH(16), .SETTLE_W(8), .ERR_W(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_stim(wr_stim),
        .wr_exp(wr_exp), .wr_mask(wr_mask), .last_idx(last_idx), .settle_cycles(settle_cycles),
        .loop_mode(loop_mode), .start(start), .stop(stop), .dut_in(dut_in), .dut_out(dut_out),
        .busy(busy), .done(done), .aborted(aborted), .err_cnt(err_cnt),
        .first_err_valid(first_err_valid), .first_err_idx(first_err_idx), .pass_cnt(pass_cnt),
        .smp_valid(smp_valid), .smp_idx(smp_idx), .smp_data(smp_data)
    );

    always #5 clk = ~clk;

    // inverter under test: 3-cycle delayed, or immediate when gate_fast
    always @(posedge clk) begin
        d1 <= ~dut_in[0];
        d2 <= d1;
        d3 <= d2;
    end
    assign dut_out = gate_fast ? ~dut_in : d3;

    typedef struct {
        logic [3:0] stim, exp, mask;
        logic [7:0] settle;
        logic       fast;
        int         err;
        logic       fev;
        int         fei;
        int         cycles;
    } vec_t;

    vec_t vecs[4];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load4(input logic [3:0] stim, input logic [3:0] exp, input logic [3:0] mask);
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_addr = AW'(i);
            wr_stim = stim[i]; wr_exp = exp[i]; wr_mask = mask[i];
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " busy"}, 32'(busy), 0);
        check({tag, " done"}, 32'(done), 0);
        check({tag, " aborted"}, 32'(aborted), 0);
        check({tag, " err_cnt"}, 32'(err_cnt), 0);
        check({tag, " first_err_valid"}, 32'(first_err_valid), 0);
        check({tag, " first_err_idx"}, 32'(first_err_idx), 0);
        check({tag, " pass_cnt"}, 32'(pass_cnt), 0);
        check({tag, " smp_valid"}, 32'(smp_valid), 0);
        check({tag, " smp_idx"}, 32'(smp_idx), 0);
        check({tag, " smp_data"}, 32'(smp_data), 0);
        check({tag, " dut_in"}, 32'(dut_in), 0);
    endtask

    task automatic run_once(input string tag, input vec_t v);
        int n, smp;
        logic b;
        n = 0; smp = 0;
        settle_cycles = v.settle; gate_fast = v.fast; last_idx = AW'(3); loop_mode = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (!done && n < 400) begin
            tick();
            n++;
            if (smp_valid) begin
                b = ~v.stim[smp[1:0]];
                check({tag, " smp_idx"}, 32'(smp_idx), 32'(smp));
                check({tag, " smp_data"}, 32'(smp_data), 32'(b));
                smp++;
            end
        end
        check({tag, " cycles"}, 32'(n), 32'(v.cycles));
        check({tag, " smp_count"}, 32'(smp), 4);
        check({tag, " err_cnt"}, 32'(err_cnt), 32'(v.err));
        check({tag, " first_err_valid"}, 32'(first_err_valid), 32'(v.fev));
        if (v.fev) check({tag, " first_err_idx"}, 32'(first_err_idx), 32'(v.fei));
        check({tag, " done"}, 32'(done), 1);
        check({tag, " aborted"}, 32'(aborted), 0);
        check({tag, " busy"}, 32'(busy), 0);
        check({tag, " dut_in_hold"}, 32'(dut_in), 32'(v.stim[3]));
    endtask

    initial begin
        int n;
        vec_t v;
        vecs[0] = '{stim: 4'b1010, exp: 4'b0101, mask: 4'b1111, settle: 8'd4, fast: 1'b0, err: 0, fev: 1'b0, fei: 0, cycles: 32};
        vecs[1] = '{stim: 4'b1010, exp: 4'b1001, mask: 4'b1111, settle: 8'd4, fast: 1'b0, err: 2, fev: 1'b1, fei: 2, cycles: 32};
        vecs[2] = '{stim: 4'b1010, exp: 4'b1001, mask: 4'b1011, settle: 8'd4, fast: 1'b0, err: 1, fev: 1'b1, fei: 3, cycles: 32};
        vecs[3] = '{stim: 4'b1010, exp: 4'b0101, mask: 4'b1111, settle: 8'd0, fast: 1'b1, err: 0, fev: 1'b0, fei: 0, cycles: 20};

        repeat (3) tick();
        check_reset_state("reset");
        rst_n = 1'b1;
        tick();

        for (int k = 0; k < 4; k++) begin
            load4(vecs[k].stim, vecs[k].exp, vecs[k].mask);
            run_once($sformatf("vec%0d", k), vecs[k]);
        end

        // loop run: pattern 3 rewritten in the same cycle as start, then a mid-run write and a stop
        load4(vecs[0].stim, vecs[0].exp, vecs[0].mask);
        settle_cycles = 8'd4; gate_fast = 1'b0; last_idx = AW'(3); loop_mode = 1'b1;
        wr_en = 1'b1; wr_addr = AW'(3); wr_stim = 1'b1; wr_exp = 1'b1; wr_mask = 1'b1;
        start = 1'b1;
        tick();
        wr_en = 1'b0; start = 1'b0;
        n = 0;
        while (pass_cnt != 8'd10 && n < 1000) begin
            tick();
            n++;
        end
        check("loop pass_cnt_reached", 32'(pass_cnt), 10);
        check("loop busy", 32'(busy), 1);
        check("loop first_err_valid", 32'(first_err_valid), 1);
        check("loop first_err_idx", 32'(first_err_idx), 3);
        wr_en = 1'b1; wr_addr = AW'(0); wr_stim = 1'b1; wr_exp = 1'b1; wr_mask = 1'b1;
        tick();
        wr_en = 1'b0; stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop done", 32'(done), 1);
        check("stop aborted", 32'(aborted), 1);
        check("stop busy", 32'(busy), 0);
        check("stop pass_cnt", 32'(pass_cnt), 10);
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        check("start_stop busy", 32'(busy), 0);
        check("start_stop aborted", 32'(aborted), 1);
        v = '{stim: 4'b1010, exp: 4'b1101, mask: 4'b1111, settle: 8'd4, fast: 1'b0, err: 1, fev: 1'b1, fei: 3, cycles: 32};
        run_once("mem_kept", v);

        // saturation: 16 always-mismatching patterns, two loop passes
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_addr = AW'(i);
            wr_stim = 1'(i); wr_exp = 1'(i); wr_mask = 1'b1;
            tick();
        end
        wr_en = 1'b0;
        settle_cycles = 8'd0; gate_fast = 1'b1; last_idx = AW'(15); loop_mode = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (pass_cnt != 8'd2 && n < 500) begin
            tick();
            n++;
        end
        check("sat pass_cnt_reached", 32'(pass_cnt), 2);
        check("sat err_cnt", 32'(err_cnt), 15);
        check("sat first_err_idx", 32'(first_err_idx), 0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("sat done", 32'(done), 1);

        // reset while pattern 1 is settling, then rerun the retained patterns
        load4(vecs[0].stim, vecs[0].exp, vecs[0].mask);
        settle_cycles = 8'd4; gate_fast = 1'b0; last_idx = AW'(3); loop_mode = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        check("mid busy", 32'(busy), 1);
        check("mid dut_in", 32'(dut_in), 1);
        rst_n = 1'b0;
        tick();
        check_reset_state("midreset");
        rst_n = 1'b1;
        run_once("rerun", vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mioc_pattern_tester.md
Name: mioc_pattern_tester

Overview:
- Synthesizable on-chip stimulus/response engine for MIOC gate characterisation; successor to file-driven bench pattern driving.
- Holds DEPTH stimulus/expected pairs and applies each to an N_IN-input gate under test.
- Waits a programmable settle time, samples the N_OUT gate outputs, compares them against masked expected values, and logs results.
- Sits between the chip's test-control register interface and the gate-under-test pins.

Parameters:
N_IN, 4, gate-under-test input count (stimulus width)
N_OUT, 1, gate-under-test output count (response width)
DEPTH, 16, pattern memory entries (power of 2, >=2)
SETTLE_W, 8, width of settle-cycle count
ERR_W, 8, width of saturating error counter

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
wr_en  in  1  pattern memory write strobe (ignored while busy)
wr_addr  in  $clog2(DEPTH)  write address
wr_stim  in  N_IN  stimulus word
wr_exp  in  N_OUT  expected response
wr_mask  in  N_OUT  compare mask; 1 = bit checked
last_idx  in  $clog2(DEPTH)  index of last pattern in run (run covers 0..last_idx)
settle_cycles  in  SETTLE_W  extra wait cycles before sampling
loop_mode  in  1  1 = repeat run until stop
start  in  1  begin run (accepted only in IDLE/DONE)
stop  in  1  abort run
dut_in  out  N_IN  registered drive to gate inputs
dut_out  in  N_OUT  asynchronous gate outputs
busy  out  1  run in progress
done  out  1  run finished or aborted; held until next start
aborted  out  1  done was caused by stop
err_cnt  out  ERR_W  mismatch count, saturates at all-ones
first_err_valid  out  1  at least one mismatch this run
first_err_idx  out  $clog2(DEPTH)  index of first mismatching pattern
pass_cnt  out  8  completed passes in loop mode, wraps
smp_valid  out  1  one-cycle pulse per sampled pattern
smp_idx  out  $clog2(DEPTH)  index of sampled pattern
smp_data  out  N_OUT  synchronised sampled response

Behaviour:
- Reset (rst_n=0 at posedge): FSM=IDLE; all outputs 0, including dut_in=0, err_cnt=0 and pass_cnt=0. Pattern memory contents are not reset.
- dut_out passes through a 2-flop synchroniser. Sampling uses the synchronised value.
- States:
  - IDLE/DONE: on start, clear err_cnt, first_err_*, pass_cnt, done and aborted; set idx=0; go to APPLY.
  - APPLY (1 cycle): dut_in<=stim[idx]; load settle counter with settle_cycles; go to SETTLE.
  - SETTLE: decrement counter; when it reaches 0 go to SYNC. settle_cycles=0 means SETTLE lasts 1 cycle.
  - SYNC (2 cycles): covers synchroniser latency; then go to SAMPLE.
  - SAMPLE (1 cycle): smp_valid=1 with smp_idx and smp_data. Mismatch when ((smp_data ^ exp[idx]) & mask[idx]) != 0.
    - On mismatch, err_cnt+1 (saturating). If first_err_valid=0, set it and latch idx.
    - If idx != last_idx: idx+1, go to APPLY.
    - Else if loop_mode: pass_cnt+1, idx=0, go to APPLY.
    - Else: go to DONE with done=1.
- Per-pattern period: 4 + max(settle_cycles,1) cycles from APPLY to SAMPLE inclusive.
- dut_in holds its last driven value in DONE and returns to 0 only on reset.
- busy=1 in APPLY, SETTLE, SYNC and SAMPLE.
- stop while busy: next state DONE; done=1, aborted=1; the current pattern is not sampled. stop has priority over a SAMPLE compare in the same cycle.
- start while busy: ignored. start and stop together in IDLE/DONE: stop wins, no run begins.
- wr_en while busy: ignored, so memory is stable during a run. Write and start in the same cycle in IDLE: the write completes and the run sees the new data.
- loop_mode is sampled at every last-pattern SAMPLE, so clearing it mid-run ends after the current pass.
- Synchronous reset mid-run returns to IDLE within one cycle. Counters clear; memory is retained.

Decomposition:
- Package mioc_tester_pkg holds the state enum (IDLE, APPLY, SETTLE, SYNC, SAMPLE, DONE) and the SYNC_STAGES=2 constant.
- One sub-module, mioc_pattern_mem: DEPTH x (N_IN+2*N_OUT) register file with 1 write port and 1 async read port.

Test Plan:
- Inverter model (N_IN=1, N_OUT=1, dut_out=~dut_in[0] with 3-cycle delay): load stim 0,1,0,1, exp 1,0,1,0, mask 1, last_idx=3, settle=4 -> done after 4x8 cycles, err_cnt=0, first_err_valid=0, 4 smp_valid pulses with idx 0..3.
- Same setup with exp[2]=0 and exp[3]=1 -> err_cnt=2, first_err_idx=2.
- Same setup with mask[2]=0 -> err_cnt=1, first_err_idx=3.
- loop_mode=1, 4 patterns, stop asserted after 10 passes -> pass_cnt=10, aborted=1, done=1, busy=0 next cycle; wr_en issued mid-run leaves memory unchanged.
- Always-mismatching DUT, ERR_W=4, DEPTH=16, 2 loop passes -> err_cnt saturates at 15.
- settle_cycles=0 -> per-pattern period is 5 cycles. rst_n=0 mid-SETTLE -> IDLE next cycle with all outputs 0; a subsequent start reruns the retained patterns correctly.
